// File: rtl/udp_rx_filter_if.sv
// udp_rx_filter_if
//   Bundles the two streaming sides of the UDP receive filter.
//   FIFO side (first-word-fall-through read port):
//     in_data/in_keep/in_last : head beat, byte n = in_data[8n+7:8n]
//     in_empty                : FIFO has no beat
//     in_rd_en                : pop the head beat this cycle
//   Output side (valid/ready stream):
//     out_data/out_keep/out_last, out_valid, out_ready
//   slave  : the filter (reads FIFO head, drives the output stream)
//   master : the environment (FIFO model and downstream sink)
interface udp_rx_filter_if;
    logic [255:0] in_data;
    logic [31:0]  in_keep;
    logic         in_last;
    logic         in_empty;
    logic         in_rd_en;
    logic [255:0] out_data;
    logic [31:0]  out_keep;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_data, in_keep, in_last, in_empty,
        output in_rd_en,
        output out_data, out_keep, out_last, out_valid,
        input  out_ready
    );

    modport master (
        output in_data, in_keep, in_last, in_empty,
        input  in_rd_en,
        input  out_data, out_keep, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/udp_rx_filter.sv
// udp_rx_filter
//   Pops 256-bit beats from a FWFT packet FIFO, parses Ethernet/IPv4/UDP
//   headers out of the first two beats and forwards frames addressed to
//   MATCH_IP:MATCH_PORT unmodified, with per-frame metadata. Everything
//   else is popped and discarded.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     bus (slave)     : FIFO read side and output stream
//     meta_valid      : high while the first beat of a frame is presented
//     meta_*          : UDP ports/length and IPv4 source of the last accepted frame
//     frame_cnt       : accepted frames (wraps)
//     drop_cnt        : dropped frames (wraps)
//     csum_err_cnt    : frames rejected only by the IPv4 header checksum
//                       (present only with UDP_RX_IPCSUM_EN defined)
//   Build option: UDP_RX_IPCSUM_EN adds IPv4 header checksum validation.
module udp_rx_filter #(
    parameter logic [15:0] MATCH_PORT = 16'd5000,
    parameter logic [31:0] MATCH_IP   = 32'hC0A8_0001,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    udp_rx_filter_if.slave   bus,
    output logic             meta_valid,
    output logic [15:0]      meta_src_port,
    output logic [15:0]      meta_dst_port,
    output logic [15:0]      meta_udp_len,
    output logic [31:0]      meta_src_ip,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
`ifdef UDP_RX_IPCSUM_EN
    ,
    output logic [CNT_W-1:0] csum_err_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_HDR1, S_FWD0, S_FWD1, S_STREAM, S_DROP} state_t;

    state_t           r_state, w_state_nxt;
    logic [255:0]     r_hold0_data, r_hold1_data, r_out_data;
    logic [31:0]      r_hold0_keep, r_hold1_keep, r_out_keep;
    logic             r_last1, r_out_last, r_out_valid, r_meta_valid;
    logic [15:0]      r_src_port, r_dst_port, r_udp_len;
    logic [31:0]      r_src_ip;
    logic [CNT_W-1:0] r_frame_cnt, r_drop_cnt;
    logic             w_rd_en, w_hs, w_hdr_ok, w_accept;

    function automatic logic [7:0] f_byte(input logic [255:0] d, input int n);
        return d[8*n +: 8];
    endfunction

    // Header fields: beat0 is held, beat1 is the FIFO head while in HDR1.
    logic [15:0] w_ethertype, w_src_port, w_dst_port, w_udp_len;
    logic [31:0] w_src_ip, w_dst_ip;
    assign w_ethertype = {f_byte(r_hold0_data, 12), f_byte(r_hold0_data, 13)};
    assign w_src_ip    = {f_byte(r_hold0_data, 26), f_byte(r_hold0_data, 27),
                          f_byte(r_hold0_data, 28), f_byte(r_hold0_data, 29)};
    assign w_dst_ip    = {f_byte(r_hold0_data, 30), f_byte(r_hold0_data, 31),
                          f_byte(bus.in_data, 0),   f_byte(bus.in_data, 1)};
    assign w_src_port  = {f_byte(bus.in_data, 2), f_byte(bus.in_data, 3)};
    assign w_dst_port  = {f_byte(bus.in_data, 4), f_byte(bus.in_data, 5)};
    assign w_udp_len   = {f_byte(bus.in_data, 6), f_byte(bus.in_data, 7)};

    // keep[7] guarantees the UDP length field is actually present in beat1.
    assign w_hdr_ok = (w_ethertype == 16'h0800) && (f_byte(r_hold0_data, 14) == 8'h45) &&
                      (f_byte(r_hold0_data, 23) == 8'h11) && (w_dst_ip == MATCH_IP) &&
                      (w_dst_port == MATCH_PORT) && bus.in_keep[7];

`ifdef UDP_RX_IPCSUM_EN
    // One's-complement sum of header bytes 14..33: nine words from beat0,
    // the last one (bytes 32-33) from beat1. Two folds absorb all carries.
    logic [19:0] w_csum_acc;
    logic [16:0] w_csum_f1;
    logic [15:0] w_csum_f2;
    logic        w_csum_ok;
    always_comb begin
        w_csum_acc = 20'd0;
        for (int i = 0; i < 9; i++)
            w_csum_acc = w_csum_acc + {4'd0, f_byte(r_hold0_data, 14 + 2*i),
                                             f_byte(r_hold0_data, 15 + 2*i)};
        w_csum_acc = w_csum_acc + {4'd0, f_byte(bus.in_data, 0), f_byte(bus.in_data, 1)};
    end
    assign w_csum_f1 = {1'b0, w_csum_acc[15:0]} + {13'd0, w_csum_acc[19:16]};
    assign w_csum_f2 = w_csum_f1[15:0] + {15'd0, w_csum_f1[16]};
    assign w_csum_ok = (w_csum_f2 == 16'hFFFF);
    assign w_accept  = w_hdr_ok && w_csum_ok;
`else
    assign w_accept  = w_hdr_ok;
`endif

    assign w_hs = r_out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rd_en = !bus.in_empty;
                if (w_rd_en && !bus.in_last) w_state_nxt = S_HDR1;
            end
            S_HDR1: begin
                w_rd_en = !bus.in_empty;
                if (w_rd_en)
                    w_state_nxt = w_accept ? S_FWD0 : (bus.in_last ? S_IDLE : S_DROP);
            end
            S_FWD0:   if (w_hs) w_state_nxt = S_FWD1;
            S_FWD1:   if (w_hs) w_state_nxt = r_last1 ? S_IDLE : S_STREAM;
            S_STREAM: begin
                // Never pop past a presented last beat: the next beat belongs
                // to the following frame and must be parsed in IDLE.
                w_rd_en = !bus.in_empty && !(r_out_valid && r_out_last) &&
                          (bus.out_ready || !r_out_valid);
                if (w_hs && r_out_last) w_state_nxt = S_IDLE;
            end
            S_DROP: begin
                w_rd_en = !bus.in_empty;
                if (w_rd_en && bus.in_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Gated so no pop is requested while reset is held.
    assign bus.in_rd_en = w_rd_en && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold0_data <= '0; r_hold0_keep <= '0;
            r_hold1_data <= '0; r_hold1_keep <= '0; r_last1 <= 1'b0;
            r_out_data   <= '0; r_out_keep   <= '0; r_out_last <= 1'b0;
            r_out_valid  <= 1'b0; r_meta_valid <= 1'b0;
            r_src_port   <= '0; r_dst_port <= '0; r_udp_len <= '0; r_src_ip <= '0;
            r_frame_cnt  <= '0; r_drop_cnt <= '0;
`ifdef UDP_RX_IPCSUM_EN
            csum_err_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_rd_en) begin
                    r_hold0_data <= bus.in_data;
                    r_hold0_keep <= bus.in_keep;
                    if (bus.in_last) r_drop_cnt <= r_drop_cnt + 1'b1;
                end
                S_HDR1: if (w_rd_en) begin
                    r_hold1_data <= bus.in_data;
                    r_hold1_keep <= bus.in_keep;
                    r_last1      <= bus.in_last;
                    if (w_accept) begin
                        r_out_data   <= r_hold0_data;
                        r_out_keep   <= r_hold0_keep;
                        r_out_last   <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_meta_valid <= 1'b1;
                        r_src_port   <= w_src_port;
                        r_dst_port   <= w_dst_port;
                        r_udp_len    <= w_udp_len;
                        r_src_ip     <= w_src_ip;
                    end else if (bus.in_last) begin
                        r_drop_cnt <= r_drop_cnt + 1'b1;
                    end
`ifdef UDP_RX_IPCSUM_EN
                    if (w_hdr_ok && !w_csum_ok) csum_err_cnt <= csum_err_cnt + 1'b1;
`endif
                end
                S_FWD0: if (w_hs) begin
                    r_out_data   <= r_hold1_data;
                    r_out_keep   <= r_hold1_keep;
                    r_out_last   <= r_last1;
                    r_meta_valid <= 1'b0;
                end
                S_FWD1: if (w_hs) begin
                    r_out_valid <= 1'b0;
                    if (r_last1) r_frame_cnt <= r_frame_cnt + 1'b1;
                end
                S_STREAM: begin
                    if (w_rd_en) begin
                        r_out_data  <= bus.in_data;
                        r_out_keep  <= bus.in_keep;
                        r_out_last  <= bus.in_last;
                        r_out_valid <= 1'b1;
                    end else if (w_hs) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_hs && r_out_last) r_frame_cnt <= r_frame_cnt + 1'b1;
                end
                S_DROP: if (w_rd_en && bus.in_last) r_drop_cnt <= r_drop_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.out_data   = r_out_data;
    assign bus.out_keep   = r_out_keep;
    assign bus.out_last   = r_out_last;
    assign bus.out_valid  = r_out_valid;
    assign meta_valid     = r_meta_valid;
    assign meta_src_port  = r_src_port;
    assign meta_dst_port  = r_dst_port;
    assign meta_udp_len   = r_udp_len;
    assign meta_src_ip    = r_src_ip;
    assign frame_cnt      = r_frame_cnt;
    assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_filter.sv
// tb_udp_rx_filter
//   Directed bench for udp_rx_filter: a FIFO model feeds table-driven frames,
//   a sink with a selectable ready pattern records forwarded beats, and the
//   recorded beats, metadata and counters are compared with hand-set values.
module tb_udp_rx_filter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    udp_rx_filter_if ifc();

    logic        meta_valid;
    logic [15:0] meta_src_port, meta_dst_port, meta_udp_len;
    logic [31:0] meta_src_ip, frame_cnt, drop_cnt;
`ifdef UDP_RX_IPCSUM_EN
    logic [31:0] csum_err_cnt;
`endif

    udp_rx_filter dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc),
        .meta_valid(meta_valid), .meta_src_port(meta_src_port),
        .meta_dst_port(meta_dst_port), .meta_udp_len(meta_udp_len),
        .meta_src_ip(meta_src_ip), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`ifdef UDP_RX_IPCSUM_EN
        , .csum_err_cnt(csum_err_cnt)
`endif
    );

    // FIFO model storage (written by main, read pointer owned by driver)
    logic [255:0] mem_d [128];
    logic [31:0]  mem_k [128];
    logic         mem_l [128];
    int wp = 0;
    int rp = 0;
    // expected forwarded beats (main only)
    logic [255:0] exp_d [128];
    logic [31:0]  exp_k [128];
    logic         exp_l [128];
    logic         exp_m [128];
    int exp_n = 0;
    // recorded beats (monitor only)
    logic [255:0] rx_d [128];
    logic [31:0]  rx_k [128];
    logic         rx_l [128];
    logic         rx_m [128];
    int rx_n = 0;

    bit do_pop = 1'b0;
    bit toggle_mode = 1'b0;
    int cyc = 0;
    int stall_viol = 0, rd_viol = 0, stalls = 0;
    logic         p_stall = 1'b0;
    logic [255:0] p_data;
    logic [31:0]  p_keep;
    logic         p_last;

    int total = 0, bad = 0;

    // FIFO head and sink ready, changed 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (do_pop) rp = rp + 1;
        if (rp < wp) begin
            ifc.in_data = mem_d[rp]; ifc.in_keep = mem_k[rp];
            ifc.in_last = mem_l[rp]; ifc.in_empty = 1'b0;
        end else begin
            ifc.in_data = '0; ifc.in_keep = '0; ifc.in_last = 1'b0; ifc.in_empty = 1'b1;
        end
        cyc = cyc + 1;
        ifc.out_ready = toggle_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end

    // Values at the falling edge are what the next rising edge acts on.
    always @(negedge clk) begin
        do_pop = ifc.in_rd_en;
        if (rst_n) begin
            if (ifc.out_valid && ifc.out_ready && rx_n < 128) begin
                rx_d[rx_n] = ifc.out_data; rx_k[rx_n] = ifc.out_keep;
                rx_l[rx_n] = ifc.out_last; rx_m[rx_n] = meta_valid;
                rx_n = rx_n + 1;
            end
            if (ifc.out_valid && !ifc.out_ready && ifc.in_rd_en) rd_viol = rd_viol + 1;
            if (p_stall && (!ifc.out_valid || ifc.out_data != p_data ||
                            ifc.out_keep != p_keep || ifc.out_last != p_last))
                stall_viol = stall_viol + 1;
            p_stall = ifc.out_valid && !ifc.out_ready;
            if (p_stall) stalls = stalls + 1;
            p_data = ifc.out_data; p_keep = ifc.out_keep; p_last = ifc.out_last;
        end else begin
            p_stall = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s act=%0h exp=%0h", nm, act, req);
        end
    endtask

    task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s act=%0h exp=%0h", nm, act, req);
        end
    endtask

    typedef struct {
        int          nbeats;
        logic [15:0] ethertype;
        logic [31:0] dst_ip;
        logic [15:0] dst_port;
        logic [15:0] src_port;
        logic [15:0] udp_len;
        bit          keep7;
        bit          toggle;
        bit          fwd;
        int          exp_frames;
        int          exp_drops;
    } vec_t;

    vec_t vt [9];

    task automatic push_frame(input vec_t v, input int seed, input logic [15:0] cs_delta);
        logic [7:0]   fb [256];
        logic [7:0]   h [20];
        logic [255:0] d;
        logic [31:0]  kp;
        int           s;
        logic [15:0]  tl, cs;
        for (int j = 0; j < 256; j++) fb[j] = 8'(seed*16 + j);
        fb[12] = v.ethertype[15:8]; fb[13] = v.ethertype[7:0];
        tl = v.udp_len + 16'd20;
        h[0] = 8'h45; h[1] = 8'h00; h[2] = tl[15:8]; h[3] = tl[7:0];
        h[4] = 8'h00; h[5] = 8'h07; h[6] = 8'h00; h[7] = 8'h00;
        h[8] = 8'h40; h[9] = 8'h11; h[10] = 8'h00; h[11] = 8'h00;
        h[12] = 8'h0A; h[13] = 8'h00; h[14] = 8'h00; h[15] = 8'h02;
        h[16] = v.dst_ip[31:24]; h[17] = v.dst_ip[23:16];
        h[18] = v.dst_ip[15:8];  h[19] = v.dst_ip[7:0];
        s = 0;
        for (int w = 0; w < 10; w++) s = s + int'({h[2*w], h[2*w+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
        cs = ~s[15:0] + cs_delta;
        h[10] = cs[15:8]; h[11] = cs[7:0];
        for (int j = 0; j < 20; j++) fb[14+j] = h[j];
        fb[34] = v.src_port[15:8]; fb[35] = v.src_port[7:0];
        fb[36] = v.dst_port[15:8]; fb[37] = v.dst_port[7:0];
        fb[38] = v.udp_len[15:8];  fb[39] = v.udp_len[7:0];
        for (int k = 0; k < v.nbeats; k++) begin
            for (int j = 0; j < 32; j++) d[8*j +: 8] = fb[32*k + j];
            if (k == 0)      kp = 32'hFFFF_FFFF;
            else if (k == 1) kp = !v.keep7 ? 32'h0000_007F :
                                  (v.nbeats == 2 ? 32'h0000_FFFF : 32'hFFFF_FFFF);
            else             kp = (k == v.nbeats-1) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
            mem_d[wp] = d; mem_k[wp] = kp; mem_l[wp] = (k == v.nbeats-1);
            wp = wp + 1;
            if (v.fwd) begin
                exp_d[exp_n] = d; exp_k[exp_n] = kp; exp_l[exp_n] = (k == v.nbeats-1);
                exp_m[exp_n] = (k == 0); exp_n = exp_n + 1;
            end
        end
    endtask

    task automatic wait_done();
        for (int c = 0; c < 400 && rp < wp; c++) @(posedge clk);
        chk("fifo_drained", 32'(wp - rp), 32'd0);
        repeat (12) @(posedge clk);
        #2;
    endtask

    int rx_cur = 0, exp_cur = 0;

    task automatic check_beats(input string tag);
        int nr, ne, n;
        nr = rx_n - rx_cur; ne = exp_n - exp_cur;
        chk({tag, "_nbeats"}, 32'(nr), 32'(ne));
        n = (nr < ne) ? nr : ne;
        for (int i = 0; i < n; i++) begin
            chkw({tag, "_data"}, rx_d[rx_cur+i], exp_d[exp_cur+i]);
            chk({tag, "_keep"}, rx_k[rx_cur+i], exp_k[exp_cur+i]);
            chk({tag, "_last"}, {31'd0, rx_l[rx_cur+i]}, {31'd0, exp_l[exp_cur+i]});
            chk({tag, "_metav"}, {31'd0, rx_m[rx_cur+i]}, {31'd0, exp_m[exp_cur+i]});
        end
        rx_cur = rx_n; exp_cur = exp_n;
    endtask

    initial begin
        int last_fwd;
        int w0;
        vec_t vv;
        //        nb  ethertype dst_ip         dport    sport    len      k7 tg fw  f  d
        vt[0] = '{3, 16'h0800, 32'hC0A8_0001, 16'd5000, 16'h1234, 16'h0040, 1, 0, 1, 1, 0};
        vt[1] = '{3, 16'h0800, 32'hC0A8_0001, 16'd5001, 16'h1234, 16'h0040, 1, 0, 0, 1, 1};
        vt[2] = '{3, 16'h0800, 32'hC0A8_0001, 16'd5000, 16'hABCD, 16'h0100, 1, 0, 1, 2, 1};
        vt[3] = '{1, 16'h0800, 32'hC0A8_0001, 16'd5000, 16'h1111, 16'h0040, 1, 0, 0, 2, 2};
        vt[4] = '{2, 16'h0800, 32'hC0A8_0001, 16'd5000, 16'h2222, 16'h0040, 0, 0, 0, 2, 3};
        vt[5] = '{5, 16'h0800, 32'hC0A8_0001, 16'd5000, 16'h5555, 16'h0080, 1, 1, 1, 3, 3};
        vt[6] = '{2, 16'h86DD, 32'hC0A8_0001, 16'd5000, 16'h3333, 16'h0040, 1, 0, 0, 3, 4};
        vt[7] = '{3, 16'h0800, 32'hC0A8_0002, 16'd5000, 16'h4444, 16'h0040, 1, 0, 0, 3, 5};
        vt[8] = '{2, 16'h0800, 32'hC0A8_0001, 16'd5000, 16'h0102, 16'h0010, 1, 0, 1, 4, 5};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, ifc.in_rd_en}, 32'd0);
        chk("rst_meta_valid", {31'd0, meta_valid}, 32'd0);
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_drop_cnt", drop_cnt, 32'd0);
        chkw("rst_out_data", ifc.out_data, 256'd0);
        chk("rst_meta_src_ip", meta_src_ip, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        last_fwd = -1;
        for (int i = 0; i < 9; i++) begin
            toggle_mode = vt[i].toggle;
            push_frame(vt[i], i, 16'd0);
            wait_done();
            check_beats($sformatf("v%0d", i));
            chk($sformatf("v%0d_frame_cnt", i), frame_cnt, 32'(vt[i].exp_frames));
            chk($sformatf("v%0d_drop_cnt", i), drop_cnt, 32'(vt[i].exp_drops));
            if (vt[i].fwd) last_fwd = i;
            if (last_fwd >= 0) begin
                chk($sformatf("v%0d_meta_sport", i), {16'd0, meta_src_port}, {16'd0, vt[last_fwd].src_port});
                chk($sformatf("v%0d_meta_dport", i), {16'd0, meta_dst_port}, 32'd5000);
                chk($sformatf("v%0d_meta_len", i), {16'd0, meta_udp_len}, {16'd0, vt[last_fwd].udp_len});
                chk($sformatf("v%0d_meta_sip", i), meta_src_ip, 32'h0A00_0002);
            end
        end
        toggle_mode = 1'b0;
        chk("stall_stable", 32'(stall_viol), 32'd0);
        chk("no_pop_in_stall", 32'(rd_viol), 32'd0);
        chk("stalls_seen", {31'd0, stalls > 0}, 32'd1);

        // reset while the fourth beat of a valid 5-beat frame waits in the FIFO
        vv = vt[5]; vv.toggle = 1'b0;
        w0 = wp;
        push_frame(vv, 20, 16'd0);
        for (int c = 0; c < 100 && rp < w0 + 3; c++) begin @(posedge clk); #2; end
        chk("rst_mid_reached", 32'(rp - w0), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("rstm_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rstm_rd_en", {31'd0, ifc.in_rd_en}, 32'd0);
        chkw("rstm_out_data", ifc.out_data, 256'd0);
        chk("rstm_frame_cnt", frame_cnt, 32'd0);
        chk("rstm_drop_cnt", drop_cnt, 32'd0);
        chk("rstm_meta_sport", {16'd0, meta_src_port}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rx_cur = rx_n; exp_cur = exp_n;
        wait_done();
        chk("resid_drop_cnt", drop_cnt, 32'd1);
        chk("resid_nbeats", 32'(rx_n - rx_cur), 32'd0);
        push_frame(vt[0], 21, 16'd0);
        wait_done();
        check_beats("post_rst");
        chk("post_rst_frame_cnt", frame_cnt, 32'd1);
        chk("post_rst_drop_cnt", drop_cnt, 32'd1);

`ifdef UDP_RX_IPCSUM_EN
        push_frame(vt[0], 22, 16'd1);
        wait_done();
        check_beats("csum_bad");
        chk("csum_bad_drop_cnt", drop_cnt, 32'd2);
        chk("csum_bad_err_cnt", csum_err_cnt, 32'd1);
        chk("csum_bad_frame_cnt", frame_cnt, 32'd1);
        push_frame(vt[2], 23, 16'd0);
        wait_done();
        check_beats("csum_ok");
        chk("csum_ok_frame_cnt", frame_cnt, 32'd2);
        chk("csum_ok_err_cnt", csum_err_cnt, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_rx_filter.md
Name: udp_rx_filter

Overview:
- Sits directly downstream of the 256-bit packet FIFO. Pops beats (data/keep/last) through a first-word-fall-through read interface.
- Parses the Ethernet/IPv4/UDP headers from the first two beats of each frame.
- Forwards matching frames unmodified on a valid/ready stream with per-frame metadata. Silently drops non-matching or malformed frames.

Parameters:
- MATCH_PORT, 16'd5000, UDP destination port accepted.
- MATCH_IP, 32'hC0A8_0001, IPv4 destination address accepted (192.168.0.1).
- CNT_W, 32, width of the frame/drop statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  256  FIFO head beat; byte n = in_data[8n+7:8n]
- in_keep  in  32  byte enables; bit n qualifies byte n
- in_last  in  1  head beat ends frame
- in_empty  in  1  FIFO empty
- in_rd_en  out  1  pop FIFO head this cycle
- out_data  out  256  forwarded beat
- out_keep  out  32  forwarded byte enables
- out_last  out  1  forwarded end of frame
- out_valid  out  1  out_* valid
- out_ready  in  1  downstream accepts
- meta_valid  out  1  high with first forwarded beat of a frame
- meta_src_port  out  16  UDP source port
- meta_dst_port  out  16  UDP destination port
- meta_udp_len  out  16  UDP length field
- meta_src_ip  out  32  IPv4 source address
- frame_cnt  out  CNT_W  accepted frames
- drop_cnt  out  CNT_W  dropped frames

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE. in_rd_en, out_valid, meta_valid =0. out_data, out_keep, out_last, meta_*, counters =0. Held beat registers cleared.
- Field byte offsets (big-endian, frame bytes):
  - ethertype 12-13
  - ver/IHL 14
  - protocol 23
  - src IP 26-29, dst IP 30-33
  - UDP src port 34-35, dst port 36-37, length 38-39
  - Beat1 byte k = frame byte 32+k.
- in_rd_en = 1 only when !in_empty and the current state consumes: IDLE, HDR1, STREAM with (out_ready or !out_valid), DROP. It is combinational from state/in_empty/out_ready.
- States:
  - IDLE: on pop, capture beat0 into hold0.
    - in_last=1 → runt: drop_cnt++, stay IDLE.
    - Otherwise → HDR1.
  - HDR1: on pop, capture beat1 into hold1 and evaluate accept. Accept = ethertype==16'h0800 && byte14==8'h45 && protocol==8'h11 && dstIP==MATCH_IP && dst port==MATCH_PORT && in_keep[7]==1.
    - Accept → FWD0; latch meta_*.
    - Reject and in_last → drop_cnt++, IDLE.
    - Reject and !in_last → DROP.
  - FWD0: out_valid=1 with hold0, out_last=0, meta_valid=1. On out_ready → FWD1.
  - FWD1: present hold1 (out_last = captured last). On handshake:
    - last → frame_cnt++, IDLE.
    - else → STREAM.
  - STREAM: registered skid. out_* load from FIFO head on pop. Frame ends when a beat with last completes the out handshake: frame_cnt++, IDLE.
  - DROP: pop every available beat. On in_last pop → drop_cnt++, IDLE.
- Output held stable while out_valid && !out_ready (AXI-stream rules). out_valid never drops without a handshake.
- meta_* stable from FWD0 until the next frame's accept. meta_valid is high only during FWD0.
- Latency: beat0 appears on out no earlier than 1 cycle after beat1 is popped. Full throughput (1 beat/cycle) in STREAM when out_ready=1 and FIFO non-empty.
- in_empty mid-frame: stall in current state, no bubble-induced errors.
- Counters wrap modulo 2^CNT_W.
- Reset mid-frame: all state lost; the remainder of a partial frame in the FIFO is parsed as a new frame (expected to fail checks and be dropped).

Optional Feature:
- Macro: UDP_RX_IPCSUM_EN.
- When defined: HDR1 additionally computes the IPv4 header one's-complement sum over frame bytes 14-33 (ten 16-bit words, end-around carry). Accept also requires sum==16'hFFFF. Frames failing only this check increment an extra output port csum_err_cnt [CNT_W-1:0] as well as drop_cnt.
- When undefined: no checksum logic and no csum_err_cnt port. The checksum field is ignored.

Test Plan:
- Valid 3-beat frame, dst IP 192.168.0.1, dst port 5000, src port 0x1234, len 0x0040, out_ready=1 → 3 beats out identical to input, meta_src_port=16'h1234, meta_udp_len=16'h0040, meta_valid=1 on beat0 only, frame_cnt=1.
- Same frame with dst port 5001 → no out_valid, all 3 beats popped, drop_cnt=1, next valid frame forwarded normally.
- Single-beat frame (in_last on beat0) → dropped, drop_cnt=1. Two-beat frame with in_keep[7]=0 on beat1 → dropped, drop_cnt=2.
- Valid 5-beat frame with out_ready toggling 1,0,0,1,… → out_* stable while stalled, no beat lost or duplicated, in_rd_en=0 during stalls in STREAM.
- Assert rst_n low during beat 3 of a valid frame → all outputs 0 asynchronously. After release, residual beats dropped; the following valid frame forwarded, frame_cnt=1.
- With UDP_RX_IPCSUM_EN: valid frame with header checksum corrupted by +1 → dropped, drop_cnt=1, csum_err_cnt=1. Correct checksum → forwarded.
